// File: rtl/cam_capture_pkg.sv
// Shared frame geometry, FSM encoding and RGB565->RGB444 slicing for the camera capture front-end.
package cam_capture_pkg;

    localparam int N_ROWS   = 120;
    localparam int M_COLS   = 160;
    localparam int AW       = 15;
    localparam int DW       = 12;
    localparam int IMG_SIZE = N_ROWS * M_COLS;
    localparam int COL_W    = 8;
    localparam int ROW_W    = 7;

    localparam logic [COL_W-1:0] COL_LIM = 8'(M_COLS);
    localparam logic [ROW_W-1:0] ROW_LIM = 7'(N_ROWS);
    localparam logic [AW-1:0]    LINE_STEP = 15'(M_COLS);

    // RGB565 bit positions inside the two camera bytes
    localparam int R_HI   = 7;
    localparam int R_LO   = 4;
    localparam int G1_HI  = 2;
    localparam int G1_LO  = 0;
    localparam int G2_BIT = 7;
    localparam int B_HI   = 4;
    localparam int B_LO   = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [DW-1:0] rgb565_to_444(input logic [7:0] byte1, input logic [7:0] byte2);
        return {byte1[R_HI:R_LO], byte1[G1_HI:G1_LO], byte2[G2_BIT], byte2[B_HI:B_LO]};
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered previous-value edge detector; rise/fall reflect the value sampled at this clock edge.
module cam_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // previous-sample register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/cam_capture.sv
// Captures one RGB565 camera frame per request into the frame buffer as RGB444, then holds done.
module cam_capture
    import cam_capture_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          init_capture,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          done,
    output logic          frame_err
);

    state_t r_state;
    state_t w_state_next;

    logic w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;

    logic             r_phase;
    logic [7:0]       r_byte1;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [AW-1:0]    r_line_base;
    logic             r_err;

    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_data;
    logic          r_mem_we;
    logic          r_done;
    logic          r_frame_err;

    logic             w_done_next;
    logic             w_start;
    logic             w_in_capture;
    logic             w_phase_cur;
    logic             w_pix_write;
    logic             w_pix_over;
    logic             w_line_end;
    logic             w_extra_line;
    logic             w_line_bad;
    logic             w_err_after;
    logic [ROW_W-1:0] w_row_after;

    cam_edge_det u_vs_edge (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_sig   (cam_vsync),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    cam_edge_det u_hr_edge (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_sig   (cam_href),
        .o_rise  (w_hr_rise),
        .o_fall  (w_hr_fall)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; dropping init_capture aborts any pending capture
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (init_capture) w_state_next = ST_WAIT_VS;
                else              w_state_next = ST_IDLE;
            end
            ST_WAIT_VS: begin
                if (!init_capture)  w_state_next = ST_IDLE;
                else if (w_vs_fall) w_state_next = ST_CAPTURE;
                else                w_state_next = ST_WAIT_VS;
            end
            ST_CAPTURE: begin
                if (!init_capture)  w_state_next = ST_IDLE;
                else if (w_vs_rise) w_state_next = ST_DONE;
                else                w_state_next = ST_CAPTURE;
            end
            ST_DONE: begin
                if (!init_capture) w_state_next = ST_IDLE;
                else               w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM output decode, registered below so done tracks the state it belongs to
    always_comb begin
        w_done_next = 1'b0;
        if (w_state_next == ST_DONE) w_done_next = 1'b1;
        else                         w_done_next = 1'b0;
    end

    // Line/pixel bookkeeping; a rising href realigns the byte pairing to the line start
    always_comb begin
        w_start      = (r_state == ST_WAIT_VS) && (w_state_next == ST_CAPTURE);
        w_in_capture = (r_state == ST_CAPTURE);
        w_phase_cur  = w_hr_rise ? 1'b0 : r_phase;
        w_pix_write  = w_in_capture && cam_href && w_phase_cur && (r_col < COL_LIM) && (r_row < ROW_LIM);
        w_pix_over   = w_in_capture && cam_href && w_phase_cur && (r_col == COL_LIM) && (r_row < ROW_LIM);
        w_line_end   = w_in_capture && w_hr_fall && (r_row < ROW_LIM);
        w_extra_line = w_in_capture && w_hr_fall && (r_row >= ROW_LIM);
        w_line_bad   = (r_col != COL_LIM) || r_phase;
        w_row_after  = w_line_end ? (r_row + 7'd1) : r_row;
        w_err_after  = r_err | (w_line_end & w_line_bad) | w_extra_line | w_pix_over;
    end

    // Capture datapath: counters, byte latch and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase     <= 1'b0;
            r_byte1     <= 8'd0;
            r_col       <= 8'd0;
            r_row       <= 7'd0;
            r_line_base <= 15'd0;
            r_err       <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_start) begin
            r_phase     <= 1'b0;
            r_col       <= 8'd0;
            r_row       <= 7'd0;
            r_line_base <= 15'd0;
            r_err       <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_in_capture) begin
            r_err <= w_err_after;
            if (w_line_end) begin
                r_row       <= r_row + 7'd1;
                r_line_base <= r_line_base + LINE_STEP;
                r_col       <= 8'd0;
                r_phase     <= 1'b0;
            end else if (cam_href) begin
                r_phase <= ~w_phase_cur;
                if (!w_phase_cur) begin
                    r_byte1 <= cam_data;
                end else if (w_pix_write) begin
                    r_col <= r_col + 8'd1;
                end
            end
            // a line ending on the same edge is already folded into w_err_after/w_row_after
            if (w_vs_rise) begin
                r_frame_err <= w_err_after | (w_row_after != ROW_LIM);
            end
        end
    end

    // Frame-buffer write port and done level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= 15'd0;
            r_mem_data <= 12'd0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mem_we <= w_pix_write;
            r_done   <= w_done_next;
            if (w_pix_write) begin
                r_mem_addr <= r_line_base + {7'd0, r_col};
                r_mem_data <= rgb565_to_444(r_byte1, cam_data);
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign mem_we    = r_mem_we;
    assign done      = r_done;
    assign frame_err = r_frame_err;

endmodule
